sevenseg_decoder: RTL and testbench



---
 rtl/sevenseg_decoder.sv | 188 ++++++++++++++++++
 tb/tb_sevenseg_decoder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sevenseg_decoder.sv
// Seven-segment receive decoder: qualifies the active-low segment bus, decodes digits 0-7 and
// delivers them over valid/ready. Define SEVENSEG_DEC_STATS_EN to build err_cnt/drop_cnt.
module sevenseg_decoder #(
    parameter int STABLE_CYCLES = 3,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [6:0]       seg_in,
    output logic [2:0]       dig_out,
    output logic             dig_valid,
    input  logic             dig_ready,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam logic [6:0]    BLANK           = 7'b1111111;
    localparam int            SW              = $clog2(STABLE_CYCLES + 1);
    localparam logic [SW-1:0] STAB_ONE        = SW'(1);
    localparam logic [SW-1:0] STAB_MAX        = SW'(STABLE_CYCLES);
    localparam bit            ACCEPT_ON_FIRST = (STABLE_CYCLES == 1);

    typedef enum logic [1:0] {IDLE, QUAL, HOLD} state_t;

    state_t        state_q, state_d;
    logic [6:0]    seg_q, seg_d;
    logic [6:0]    cand_q, cand_d;
    logic [6:0]    last_q, last_d;
    logic [SW-1:0] stab_q, stab_d;
    logic [2:0]    dig_q, dig_d;
    logic          dig_valid_q, dig_valid_d;
    logic          err_q, err_d;
    logic          pat_valid;
    logic [2:0]    pat_digit;
    logic          accept, load, drop, consume;

    assign seg_d = seg_in;

    // Anything outside the eight digit codes (BLANK, other codes, X/Z bits) decodes as invalid.
    always_comb begin
        pat_valid = 1'b1;
        pat_digit = 3'd0;
        case (seg_q)
            7'b1000000: pat_digit = 3'd0;
            7'b1111001: pat_digit = 3'd1;
            7'b0100100: pat_digit = 3'd2;
            7'b0110000: pat_digit = 3'd3;
            7'b0011001: pat_digit = 3'd4;
            7'b0010010: pat_digit = 3'd5;
            7'b0000010: pat_digit = 3'd6;
            7'b1111000: pat_digit = 3'd7;
            default:    pat_valid = 1'b0;
        endcase
    end

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d = state_q;
        cand_d  = cand_q;
        stab_d  = stab_q;
        last_d  = last_q;
        accept  = 1'b0;
        load    = 1'b0;
        err_d   = 1'b0;
        if (!en) begin
            state_d = IDLE;
            cand_d  = BLANK;
            last_d  = BLANK;
            stab_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (seg_q != BLANK) begin
                        cand_d  = seg_q;
                        stab_d  = STAB_ONE;
                        state_d = QUAL;
                        accept  = ACCEPT_ON_FIRST;
                    end
                end
                QUAL, HOLD: begin
                    if (seg_q != cand_q) begin
                        cand_d  = seg_q;
                        stab_d  = STAB_ONE;
                        state_d = QUAL;
                        accept  = ACCEPT_ON_FIRST;
                    end else if (state_q == QUAL) begin
                        stab_d = stab_q + STAB_ONE;
                        accept = (stab_d == STAB_MAX);
                    end
                end
                default: state_d = IDLE;
            endcase

            // At acceptance seg_q always equals the candidate being accepted.
            if (accept) begin
                if (seg_q == BLANK) begin
                    last_d  = BLANK;
                    state_d = IDLE;
                end else if (seg_q == last_q) begin
                    state_d = HOLD;
                end else begin
                    last_d  = seg_q;
                    state_d = HOLD;
                    load    = pat_valid;
                    err_d   = ~pat_valid;
                end
            end
        end
    end

    // A consumed slot can be refilled in the same cycle without counting a drop.
    always_comb begin
        consume     = dig_valid_q & dig_ready;
        dig_d       = dig_q;
        dig_valid_d = dig_valid_q & ~consume;
        drop        = 1'b0;
        if (load) begin
            if (!dig_valid_q || consume) begin
                dig_d       = pat_digit;
                dig_valid_d = 1'b1;
            end else begin
                drop = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
        if (rst) begin
            state_q     <= IDLE;
            seg_q       <= BLANK;
            cand_q      <= BLANK;
            last_q      <= BLANK;
            stab_q      <= '0;
            dig_q       <= 3'd0;
            dig_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            seg_q       <= seg_d;
            cand_q      <= cand_d;
            last_q      <= last_d;
            stab_q      <= stab_d;
            dig_q       <= dig_d;
            dig_valid_q <= dig_valid_d;
            err_q       <= err_d;
        end
    end

    assign dig_out   = dig_q;
    assign dig_valid = dig_valid_q;
    assign err       = err_q;

`ifdef SEVENSEG_DEC_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        err_cnt_d  = err_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (err_d && err_cnt_q != CNT_MAX) err_cnt_d = err_cnt_q + CNT_W'(1);
        if (drop && drop_cnt_q != CNT_MAX) drop_cnt_d = drop_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            err_cnt_q  <= err_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign err_cnt  = err_cnt_q;
    assign drop_cnt = drop_cnt_q;
`else
    logic unused_drop;
    assign unused_drop = drop;
    assign err_cnt     = '0;
    assign drop_cnt    = '0;
`endif

endmodule

// File: tb/tb_sevenseg_decoder.sv
// Bench for sevenseg_decoder: a STABLE_CYCLES=3 instance driven from a vector table with a digit
// scoreboard, plus a STABLE_CYCLES=1, CNT_W=2 instance for latency and counter saturation.
module tb_sevenseg_decoder;

    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] P0 = 7'b1000000, P1 = 7'b1111001, P2 = 7'b0100100, P3 = 7'b0110000;
    localparam logic [6:0] P4 = 7'b0011001, P5 = 7'b0010010, P6 = 7'b0000010, P7 = 7'b1111000;

`ifdef SEVENSEG_DEC_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct {
        logic [6:0] seg;
        int         hold;
        bit         push;
        logic [2:0] digit;
        bit         is_err;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst, en, dig_ready;
    logic [6:0] seg_in;
    logic [2:0] dig_out;
    logic       dig_valid, err;
    logic [7:0] err_cnt, drop_cnt;

    logic       en2, ready2;
    logic [6:0] seg2;
    logic [2:0] dig_out2;
    logic       dig_valid2, err2;
    logic [1:0] err_cnt2, drop_cnt2;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [2:0] exp_q[$];
    vec_t       vecs[$];
    int         exp_err  = 0;
    int         exp_drop = 0;
    int         err_seen = 0;
    int         err_seen2 = 0;
    logic       err_prev = 1'b0;
    logic       err2_prev = 1'b0;

    always #5 clk = ~clk;

    sevenseg_decoder #(.STABLE_CYCLES(3), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .en(en), .seg_in(seg_in),
        .dig_out(dig_out), .dig_valid(dig_valid), .dig_ready(dig_ready),
        .err(err), .err_cnt(err_cnt), .drop_cnt(drop_cnt)
    );

    sevenseg_decoder #(.STABLE_CYCLES(1), .CNT_W(2)) u_dut_s1 (
        .clk(clk), .rst(rst), .en(en2), .seg_in(seg2),
        .dig_out(dig_out2), .dig_valid(dig_valid2), .dig_ready(ready2),
        .err(err2), .err_cnt(err_cnt2), .drop_cnt(drop_cnt2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int exp_cnt(input int n, input int w);
        int max_v;
        max_v = (1 << w) - 1;
        if (!STATS) return 0;
        return (n > max_v) ? max_v : n;
    endfunction

    function automatic vec_t mk(input logic [6:0] seg, input int hold, input bit push,
                                input logic [2:0] digit, input bit is_err);
        vec_t v;
        v.seg = seg; v.hold = hold; v.push = push; v.digit = digit; v.is_err = is_err;
        return v;
    endfunction

    // Scoreboard: every handshake pops the oldest expected digit.
    always @(negedge clk) begin
        if (!rst) begin
            if (dig_valid && dig_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_digit: got %0d, expected no delivery", dig_out);
                end else begin
                    check("scoreboard_digit", dig_out, exp_q.pop_front());
                end
            end
            if (err) begin
                err_seen++;
                check("err_single_cycle", err_prev, 0);
            end
            err_prev = err;
            if (err2) err_seen2++;
            err2_prev = err2;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish within time limit");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; en = 1'b1; seg_in = BLANK; dig_ready = 1'b1;
        en2 = 1'b1; seg2 = BLANK; ready2 = 1'b1;
        tick(2);
        check("reset_dig_valid", dig_valid, 0);
        check("reset_dig_out", dig_out, 0);
        check("reset_err", err, 0);
        check("reset_err_cnt", err_cnt, 0);
        check("reset_drop_cnt", drop_cnt, 0);
        check("reset_dig_valid2", dig_valid2, 0);
        rst = 1'b0;

        // Digit 5 held exactly STABLE_CYCLES: valid only after the following edge, for one cycle.
        seg_in = P5;
        exp_q.push_back(3'd5);
        tick(3);
        check("lat_not_yet_valid", dig_valid, 0);
        seg_in = BLANK;
        tick(1);
        check("lat_valid", dig_valid, 1);
        check("lat_digit", dig_out, 5);
        tick(1);
        check("lat_valid_falls", dig_valid, 0);
        tick(4);

        vecs.push_back(mk(P3,    10, 1'b1, 3'd3, 1'b0));
        vecs.push_back(mk(BLANK,  1, 1'b0, 3'd0, 1'b0));  // glitch shorter than qualification
        vecs.push_back(mk(P3,     5, 1'b0, 3'd0, 1'b0));
        vecs.push_back(mk(BLANK,  4, 1'b0, 3'd0, 1'b0));
        vecs.push_back(mk(P1,     4, 1'b1, 3'd1, 1'b0));
        vecs.push_back(mk(BLANK,  4, 1'b0, 3'd0, 1'b0));
        vecs.push_back(mk(P1,     4, 1'b1, 3'd1, 1'b0));
        vecs.push_back(mk(P0,     4, 1'b1, 3'd0, 1'b0));
        vecs.push_back(mk(P6,     4, 1'b1, 3'd6, 1'b0));
        vecs.push_back(mk(P4,     4, 1'b1, 3'd4, 1'b0));
        vecs.push_back(mk(P7,     4, 1'b1, 3'd7, 1'b0));
        vecs.push_back(mk(P2,     4, 1'b1, 3'd2, 1'b0));
        vecs.push_back(mk(BLANK,  4, 1'b0, 3'd0, 1'b0));
        vecs.push_back(mk(P4,     2, 1'b0, 3'd0, 1'b0));  // one sample short of acceptance
        vecs.push_back(mk(BLANK,  4, 1'b0, 3'd0, 1'b0));
        vecs.push_back(mk(7'b1010101, 3, 1'b0, 3'd0, 1'b1));
        vecs.push_back(mk(BLANK,  4, 1'b0, 3'd0, 1'b0));
        vecs.push_back(mk(7'b0000000, 8, 1'b0, 3'd0, 1'b1));
        vecs.push_back(mk(BLANK,  4, 1'b0, 3'd0, 1'b0));

        for (int i = 0; i < vecs.size(); i++) begin
            seg_in = vecs[i].seg;
            if (vecs[i].push) exp_q.push_back(vecs[i].digit);
            if (vecs[i].is_err) exp_err++;
            tick(vecs[i].hold);
        end
        seg_in = BLANK;
        tick(6);
        check("table_all_delivered", exp_q.size(), 0);
        check("table_err_pulses", err_seen, exp_err);
        check("table_err_cnt", err_cnt, exp_cnt(exp_err, 8));
        check("table_drop_cnt", drop_cnt, exp_cnt(exp_drop, 8));
        check("table_no_valid", dig_valid, 0);

        // Full slot: 2 stays presented, 7 is dropped.
        dig_ready = 1'b0;
        seg_in = P2;
        exp_q.push_back(3'd2);
        tick(4);
        seg_in = P7;
        tick(4);
        exp_drop++;
        seg_in = BLANK;
        tick(4);
        check("drop_valid_held", dig_valid, 1);
        check("drop_digit_held", dig_out, 2);
        check("drop_cnt", drop_cnt, exp_cnt(exp_drop, 8));
        dig_ready = 1'b1;
        tick(1);
        check("drop_drained_valid", dig_valid, 0);
        check("drop_drained_queue", exp_q.size(), 0);

        // en low for one cycle while digit 4 qualifies: nothing emerges.
        seg_in = P4;
        tick(2);
        en = 1'b0;
        tick(1);
        en = 1'b1;
        seg_in = BLANK;
        tick(6);
        check("en_drop_no_valid", dig_valid, 0);
        check("en_drop_err_pulses", err_seen, exp_err);

        // Reset with a pending digit.
        dig_ready = 1'b0;
        seg_in = P6;
        tick(4);
        seg_in = BLANK;
        tick(2);
        check("pre_rst_valid", dig_valid, 1);
        check("pre_rst_digit", dig_out, 6);
        rst = 1'b1;
        tick(1);
        check("rst_mid_valid", dig_valid, 0);
        check("rst_mid_digit", dig_out, 0);
        check("rst_mid_err", err, 0);
        check("rst_mid_err_cnt", err_cnt, 0);
        check("rst_mid_drop_cnt", drop_cnt, 0);
        rst = 1'b0;
        dig_ready = 1'b1;
        tick(8);
        check("post_rst_no_valid", dig_valid, 0);
        check("post_rst_queue", exp_q.size(), 0);

        // STABLE_CYCLES=1: accepted two edges after first sampled.
        err_seen2 = 0;
        seg2 = P5;
        tick(1);
        check("s1_not_yet_valid", dig_valid2, 0);
        tick(1);
        check("s1_valid", dig_valid2, 1);
        check("s1_digit", dig_out2, 5);
        seg2 = BLANK;
        tick(1);
        check("s1_valid_falls", dig_valid2, 0);
        tick(2);

        // Five distinct invalid patterns saturate a 2-bit counter at 3.
        for (int i = 0; i < 5; i++) begin
            logic [6:0] bad_pats [5];
            bad_pats = '{7'b1010101, 7'b0000000, 7'b0101010, 7'b1100110, 7'b0001111};
            seg2 = bad_pats[i];
            tick(2);
            check("s1_err_cnt_sat", err_cnt2, exp_cnt(i + 1, 2));
        end
        seg2 = BLANK;
        tick(3);
        check("s1_err_pulses", err_seen2, 5);
        check("s1_no_digit", dig_valid2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
